// File: rtl/instruction_fetch_if.sv
// Fetch-stage bus: run control, redirects, program-load port and the
// fetched-instruction outputs handed to decode.
interface instruction_fetch_if #(
   parameter int NB        = 32,
   parameter int MEM_WORDS = 64
);
   localparam int AW = $clog2(MEM_WORDS);

   logic          i_step;
   logic          i_start;
   logic          i_stall;
   logic          i_jump;
   logic [NB-1:0] i_jump_addr;
   logic          i_branch_taken;
   logic [NB-1:0] i_branch_addr;
   logic          i_load_en;
   logic [AW-1:0] i_load_addr;
   logic [NB-1:0] i_load_data;
   logic [NB-1:0] o_pc;
   logic [NB-1:0] o_instruction;
   logic [NB-1:0] o_pc4;
   logic          o_halt;

   modport master (
      output i_step, i_start, i_stall, i_jump, i_jump_addr,
             i_branch_taken, i_branch_addr, i_load_en, i_load_addr, i_load_data,
      input  o_pc, o_instruction, o_pc4, o_halt
   );

   modport slave (
      input  i_step, i_start, i_stall, i_jump, i_jump_addr,
             i_branch_taken, i_branch_addr, i_load_en, i_load_addr, i_load_data,
      output o_pc, o_instruction, o_pc4, o_halt
   );
endinterface

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: PC sequencing with branch/jump/stall priority,
// loadable instruction memory and an IDLE/RUN/HALTED run controller.
module instruction_fetch #(
   parameter int              NB        = 32,
   parameter int              MEM_WORDS = 64,
   parameter logic [NB-1:0]   HALT_WORD = 32'hFFFF_FFFF
) (
   input  logic                i_clk,
   input  logic                i_reset,
   instruction_fetch_if.slave  bus
);
   localparam int AW = $clog2(MEM_WORDS);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] RUN    = 2'd1;
   localparam logic [1:0] HALTED = 2'd2;

   localparam logic [NB-1:0] PC_INC = NB'(4);

   logic [1:0]    state_q, state_d;
   logic [NB-1:0] pc_q, pc_d;
   logic [NB-1:0] instr_q, instr_d;
   logic [NB-1:0] pc4_q, pc4_d;
   logic [NB-1:0] mem_q [MEM_WORDS];
   logic          mem_we_s;
   logic [NB-1:0] fetch_word_s;

   // Out-of-range PCs wrap because only the word-index bits address memory.
   assign fetch_word_s = mem_q[pc_q[AW+1:2]];

   // A load landing on the same edge as reset must not reach the array.
   assign mem_we_s = bus.i_load_en && (state_q == IDLE) && i_reset;

   // Next-state, PC and fetch-latch selection.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      instr_d = instr_q;
      pc4_d   = pc4_q;
      case (state_q)
         IDLE: begin
            if (bus.i_start) begin
               state_d = RUN;
            end else begin
               state_d = IDLE;
            end
         end
         RUN: begin
            if (!bus.i_step) begin
               state_d = RUN;
            end else if (bus.i_branch_taken) begin
               pc_d    = bus.i_branch_addr;
               instr_d = '0;
               pc4_d   = '0;
            end else if (bus.i_jump) begin
               pc_d    = bus.i_jump_addr;
               instr_d = '0;
               pc4_d   = '0;
            end else if (bus.i_stall) begin
               state_d = RUN;
            end else if (fetch_word_s == HALT_WORD) begin
               // Halt word is latched for decode but the PC stays on it.
               instr_d = fetch_word_s;
               pc4_d   = pc_q + PC_INC;
               state_d = HALTED;
            end else begin
               instr_d = fetch_word_s;
               pc4_d   = pc_q + PC_INC;
               pc_d    = pc_q + PC_INC;
            end
         end
         HALTED: begin
            state_d = HALTED;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Control and pipeline-register state.
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         state_q <= IDLE;
         pc_q    <= '0;
         instr_q <= '0;
         pc4_q   <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         instr_q <= instr_d;
         pc4_q   <= pc4_d;
      end
   end

   // Program memory survives reset so a loaded program can be rerun.
   always_ff @(posedge i_clk) begin
      if (mem_we_s) begin
         mem_q[bus.i_load_addr] <= bus.i_load_data;
      end
   end

   assign bus.o_pc          = pc_q;
   assign bus.o_instruction = instr_q;
   assign bus.o_pc4         = pc4_q;
   assign bus.o_halt        = (state_q == HALTED);
endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter NB, 32, datapath/instruction/PC width.
REQ-002 Parameter MEM_WORDS, 64, instruction memory depth in words (power of two).
REQ-003 Parameter HALT_WORD, 32'hFFFF_FFFF, encoding that stops fetch.
REQ-004 i_clk  in  1  single clock; all state on rising edge.
REQ-005 i_reset  in  1  asynchronous, active-low reset (0 = reset).
REQ-006 i_step  in  1  advance enable for PC, fetch latch and FSM in RUN.
REQ-007 i_start  in  1  pulse; IDLE -> RUN.
REQ-008 i_stall  in  1  hold request from decode hazard logic.
REQ-009 i_jump / i_jump_addr  in  1 / NB  jump redirect from decode.
REQ-010 i_branch_taken / i_branch_addr  in  1 / NB  branch redirect from later stage.
REQ-011 i_load_en / i_load_addr / i_load_data  in  1 / log2(MEM_WORDS) / NB  program-load write port.
REQ-012 o_pc  out  NB  current PC.
REQ-013 o_instruction  out  NB  registered fetched word for decode.
REQ-014 o_pc4  out  NB  registered PC+4 paired with o_instruction.
REQ-015 o_halt  out  1  high while in HALTED.

Function
REQ-016 FSM states SHALL be IDLE, RUN, HALTED.
REQ-017 IDLE: i_start=1 -> RUN next edge; PC, latch unchanged.
REQ-018 IDLE: i_load_en=1 SHALL write i_load_data to word i_load_addr next edge; i_load_en ignored in RUN/HALTED.
REQ-019 RUN with i_step=0: all state SHALL hold.
REQ-020 RUN, i_step=1, priority: branch_taken > jump > stall > sequential.
REQ-021 Branch: PC <= i_branch_addr; o_instruction <= 0 (NOP); o_pc4 <= 0; i_stall ignored.
REQ-022 Jump (no branch): PC <= i_jump_addr; o_instruction <= 0; o_pc4 <= 0; i_stall ignored.
REQ-023 Stall (no redirect): PC, o_instruction, o_pc4 SHALL hold.
REQ-024 Sequential: o_instruction <= mem[PC[log2(MEM_WORDS)+1:2]]; o_pc4 <= PC+4; PC <= PC+4 (mod 2^NB).
REQ-025 Fetch latency: word at PC visible on o_instruction one stepped edge after PC presented.
REQ-026 Memory index SHALL use PC bits [log2(MEM_WORDS)+1:2] only; out-of-range PC wraps; PC[1:0] ignored.
REQ-027 Sequential fetch of HALT_WORD: latch HALT_WORD into o_instruction, PC SHALL NOT advance, state -> HALTED same edge.
REQ-028 Redirect same cycle as HALT_WORD fetch: redirect wins, NOP latched, no halt.
REQ-029 HALTED: PC, o_instruction, o_pc4 hold regardless of i_step, i_start, redirects; o_halt=1; exit only via reset.
REQ-030 o_halt combinationally equals (state==HALTED).
REQ-031 i_start outside IDLE SHALL be ignored.

Reset
REQ-032 i_reset=0 SHALL immediately force PC=0, o_instruction=0, o_pc4=0, state=IDLE, o_halt=0, independent of i_clk.
REQ-033 Instruction memory contents SHALL NOT be cleared by reset; a reload after reset is optional.
REQ-034 Reset asserted mid-RUN or mid-load SHALL abort; the load write at that edge SHALL NOT occur.

Verification
REQ-035 Load words 0..3 = 0x20010005, 0x20020007, 0x00221820, HALT_WORD; start; step 4x -> o_instruction sequence matches, o_pc4 = 4,8,12,16 then o_halt=1, o_pc=0x0C.
REQ-036 RUN at PC=0x08 with i_stall=1 for 3 stepped edges -> PC, o_instruction unchanged; release -> PC=0x0C.
REQ-037 PC=0x04, i_jump=1 addr 0x20 and i_branch_taken=1 addr 0x40 same edge -> PC=0x40, o_instruction=0.
REQ-038 PC=0x08, i_step=0 for 5 edges with i_jump=1 -> no change; i_step=1 -> PC=jump target.
REQ-039 PC=MEM_WORDS*4 (0x100) -> fetches word 0 (wrap); HALT_WORD at word 2 with simultaneous branch -> no halt, PC=branch target.
REQ-040 Assert i_reset=0 between clock edges during RUN -> outputs zero immediately, state IDLE; memory retains loaded program, restart reproduces REQ-035.
